// File: rtl/note_voice_arbiter.sv
// Debounces the five piano keys and sequences a single note generator at a time:
// newest press wins, each note holds a minimum time, and a silent gap separates notes.
module note_voice_arbiter #(
  parameter int NUM_NOTES       = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MIN_HOLD_CYCLES = 5_000_000,
  parameter int GAP_CYCLES      = 100_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_NOTES-1:0]         key_in,
  output logic [NUM_NOTES-1:0]         key_stable,
  output logic [NUM_NOTES-1:0]         note_en,
  output logic [$clog2(NUM_NOTES)-1:0] note_idx,
  output logic                         playing
);

  // state | meaning
  // IDLE  | silent, waiting for any key press
  // PLAY  | note_en = onehot(cur), hold counting down
  // GAP   | silent between two notes, pending plays when gap expires

  localparam int IW = $clog2(NUM_NOTES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(MIN_HOLD_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_HOLD_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  logic [NUM_NOTES-1:0] sync1, sync2, key_stable_d;
  logic [DW-1:0]        deb_cnt [NUM_NOTES];
  logic [NUM_NOTES-1:0] press, cur_mask, press_other, held_other;

  state_t               state, state_nxt;
  logic [IW-1:0]        cur, cur_nxt, pending, pending_nxt;
  logic [HW-1:0]        hold, hold_nxt, hold_dec;
  logic [GW-1:0]        gap, gap_nxt;
  logic [NUM_NOTES-1:0] en_nxt;
  logic [IW-1:0]        idx_nxt;

  function automatic logic [IW-1:0] lowest(input logic [NUM_NOTES-1:0] v);
    lowest = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--)
      if (v[i]) lowest = IW'(i);
  endfunction

  function automatic logic [NUM_NOTES-1:0] onehot(input logic [IW-1:0] idx);
    onehot = '0;
    for (int i = 0; i < NUM_NOTES; i++)
      if (IW'(i) == idx) onehot[i] = 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1        <= '0;
      sync2        <= '0;
      key_stable   <= '0;
      key_stable_d <= '0;
      for (int i = 0; i < NUM_NOTES; i++) deb_cnt[i] <= '0;
    end else begin
      sync1        <= key_in;
      sync2        <= sync1;
      key_stable_d <= key_stable;
      for (int i = 0; i < NUM_NOTES; i++) begin
        if (sync2[i] == key_stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i]    <= '0;
          key_stable[i] <= ~key_stable[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press       = key_stable & ~key_stable_d;
  assign cur_mask    = onehot(cur);
  assign press_other = press & ~cur_mask;
  assign held_other  = key_stable & ~cur_mask;
  assign hold_dec    = (hold != '0) ? hold - 1'b1 : '0;

  // Outputs are registered with the state so note_en/note_idx/playing move together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur      <= '0;
      pending  <= '0;
      hold     <= '0;
      gap      <= '0;
      note_en  <= '0;
      note_idx <= '0;
      playing  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cur      <= cur_nxt;
      pending  <= pending_nxt;
      hold     <= hold_nxt;
      gap      <= gap_nxt;
      note_en  <= en_nxt;
      note_idx <= idx_nxt;
      playing  <= (state_nxt == S_PLAY);
    end
  end

  always_comb begin
    state_nxt   = state;
    cur_nxt     = cur;
    pending_nxt = pending;
    hold_nxt    = hold;
    gap_nxt     = gap;
    unique case (state)
      S_IDLE: begin
        if (|press) begin
          state_nxt = S_PLAY;
          cur_nxt   = lowest(press);
          hold_nxt  = HOLD_LOAD;
        end
      end
      S_PLAY: begin
        hold_nxt = hold_dec;
        if (|press_other) begin
          state_nxt   = S_GAP;
          pending_nxt = lowest(press_other);
          gap_nxt     = GAP_LOAD;
        end else if (|(press & cur_mask)) begin
          hold_nxt = HOLD_LOAD;
        // Expiry looks at the decremented count so a note lasts exactly MIN_HOLD_CYCLES.
        end else if (hold_dec == '0 && !(|(key_stable & cur_mask))) begin
          if (|held_other) begin
            state_nxt   = S_GAP;
            pending_nxt = lowest(held_other);
            gap_nxt     = GAP_LOAD;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        gap_nxt = (gap != '0) ? gap - 1'b1 : '0;
        if (|press) pending_nxt = lowest(press);
        if (gap == GW'(1)) begin
          state_nxt = S_PLAY;
          cur_nxt   = pending_nxt;
          hold_nxt  = HOLD_LOAD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    en_nxt  = '0;
    idx_nxt = '0;
    if (state_nxt == S_PLAY) begin
      en_nxt  = onehot(cur_nxt);
      idx_nxt = cur_nxt;
    end
  end

endmodule
